// File: rtl/protocol_pkg.sv
// protocol_pkg: shared oscillator and mixer protocol types and constants.
//   FIXED_POINT_W : fractional bits added on top of the oscillator amplitude width
//   N_OSC         : number of time-multiplexed oscillator voices
//   osc_shape_t   : oscillator waveform selector
//   mixer_state_t : mixer sequencer states
`ifndef CONSTANTS_SVH
`include "constants.svh"
`endif
package protocol_pkg;
  localparam int FIXED_POINT_W = `FIXED_POINT;
  localparam int N_OSC = `N_OSCILLATORS;
  typedef enum logic [1:0] {OSC_SINE, OSC_SQUARE, OSC_SAW, OSC_TRIANGLE} osc_shape_t;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} mixer_state_t;
endpackage

// File: rtl/constants.svh
// constants.svh: global fixed-point and oscillator-count settings.
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH
`define FIXED_POINT 8
`define N_OSCILLATORS 4
`endif

// File: rtl/sat_shift.sv
// sat_shift: arithmetic right shift, then clamp (SATURATE=1) or truncate (SATURATE=0) to OUT_W.
//   din  in  IN_W signed   value to scale (IN_W >= OUT_W)
//   dout out OUT_W signed  scaled result
module sat_shift #(
  parameter int IN_W = 35,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter bit SATURATE = 1'b1
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);
  if (SATURATE) begin : g_sat
    localparam logic signed [IN_W-1:0] MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    logic signed [IN_W-1:0] sh;
    assign sh = din >>> SHIFT;
    assign dout = sh > MAX ? OUT_W'(MAX) : sh < MIN ? OUT_W'(MIN) : sh[OUT_W-1:0];
  end else begin : g_wrap
    assign dout = OUT_W'(din >>> SHIFT);
  end
endmodule

// File: rtl/wavegen_mixer.sv
// wavegen_mixer: per-frame oscillator voice sequencer, accumulator and scaled mixer.
//   clk, rstn (sync active-low), sample_tick  : clock, reset, frame start pulse
//   osc_index out                             : voice index to oscillator, N_WAVEGENS = idle
//   osc_out, osc_enabled in                   : sample/enable for current osc_index
//   mix_out, mix_valid, voice_active out      : frame result, one-cycle update strobe, enable snapshot
//   busy, overrun out                         : frame in progress, sticky tick-during-scan flag
// Macro WAVEGEN_MIXER_SATURATE_EN: clamp mix_out instead of wrapping.
module wavegen_mixer
  import protocol_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int N_WAVEGENS = N_OSC,
  parameter int GAIN_SHIFT = $clog2(N_WAVEGENS),
  localparam int OW = WIDTH + FIXED_POINT_W,
  localparam int IW = $clog2(N_WAVEGENS + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sample_tick,
  output logic [IW-1:0]         osc_index,
  input  logic signed [OW-1:0]  osc_out,
  input  logic                  osc_enabled,
  output logic signed [OW-1:0]  mix_out,
  output logic                  mix_valid,
  output logic [N_WAVEGENS-1:0] voice_active,
  output logic                  busy,
  output logic                  overrun
);
  localparam int AW = OW + $clog2(N_WAVEGENS) + 1;
  localparam logic [IW-1:0] IDLE_IDX = IW'(N_WAVEGENS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_WAVEGENS - 1);
`ifdef WAVEGEN_MIXER_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  mixer_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [N_WAVEGENS-1:0] shadow_q, shadow_d, vact_q, vact_d;
  logic signed [OW-1:0] mix_q, mix_d, scaled;
  logic valid_q, valid_d, ovr_q, ovr_d, restart;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      idx_q    <= IDLE_IDX;
      acc_q    <= '0;
      shadow_q <= '0;
      vact_q   <= '0;
      mix_q    <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      vact_q   <= vact_d;
      mix_q    <= mix_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = sample_tick ? SCAN : IDLE;
      SCAN:    state_d = idx_q == LAST_IDX ? DONE : SCAN;
      DONE:    state_d = sample_tick ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // A tick only starts a frame from IDLE or DONE; during SCAN it just flags overrun.
  assign restart = sample_tick && state_q != SCAN;
  always_comb begin
    idx_d = restart ? '0 : state_q == SCAN && idx_q != LAST_IDX ? idx_q + 1'b1 : IDLE_IDX;
    acc_d = restart ? '0 : state_q == SCAN ? acc_q + AW'(osc_out) : acc_q;
    shadow_d = shadow_q;
    for (int i = 0; i < N_WAVEGENS; i++)
      shadow_d[i] = state_q == SCAN && idx_q == IW'(i) ? osc_enabled : shadow_q[i];
    mix_d   = state_q == DONE ? scaled : mix_q;
    vact_d  = state_q == DONE ? shadow_q : vact_q;
    valid_d = state_q == DONE;
    ovr_d   = ovr_q | (state_q == SCAN && sample_tick);
  end
  sat_shift #(.IN_W(AW), .OUT_W(OW), .SHIFT(GAIN_SHIFT), .SATURATE(SAT_EN)) u_sat (
    .din(acc_q), .dout(scaled)
  );
  assign osc_index    = idx_q;
  assign mix_out      = mix_q;
  assign mix_valid    = valid_q;
  assign voice_active = vact_q;
  assign busy         = state_q != IDLE;
  assign overrun      = ovr_q;
endmodule
